// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants: state encoding, instruction size,
// default NOP and the registered decode-side payload.
package fetch_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_out_t;

  // Redirect targets are always word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            imem_rvalid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_rvalid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_rvalid
  );

endinterface

// File: rtl/fetch_unit_next_pc_mux.sv
// Next-PC selection: jump over branch over sequential advance, with redirect
// targets forced to word alignment.
module fetch_unit_next_pc_mux
  import fetch_unit_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            jump_en,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_pc_plus4,
  input  logic [XLEN-1:0] branch_offset,
  output logic [XLEN-1:0] next_pc_c,
  output logic            redirect_c
);

  assign redirect_c = jump_en | branch_taken;

  always_comb begin
    next_pc_c = pc;
    if (jump_en) begin
      next_pc_c = align_word(jump_target);
    end else if (branch_taken) begin
      next_pc_c = align_word(branch_pc_plus4 + branch_offset);
    end else if (advance) begin
      next_pc_c = pc + XLEN'(INSTR_BYTES);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, single-outstanding imem requests and a
// registered one-entry valid/stall hand-off to decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_pc_plus4,
  input  logic [XLEN-1:0]   branch_offset,
  input  logic              jump_en,
  input  logic [XLEN-1:0]   jump_target,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_instr,
  output logic [XLEN-1:0]   if_pc,
  output logic [XLEN-1:0]   if_pc_plus4
);

  fetch_state_t    state, state_d;
  logic [XLEN-1:0] pc, next_pc_c;
  logic            redirect_c;
  logic            advance_c;
  logic            valid_q, valid_d;
  fetch_out_t      out_q, out_d;

  // Sequential advance only when decode accepts the held instruction.
  assign advance_c = (state == HOLD) && !stall;

  fetch_unit_next_pc_mux next_pc_mux (
    .pc              (pc),
    .advance         (advance_c),
    .jump_en         (jump_en),
    .jump_target     (jump_target),
    .branch_taken    (branch_taken),
    .branch_pc_plus4 (branch_pc_plus4),
    .branch_offset   (branch_offset),
    .next_pc_c       (next_pc_c),
    .redirect_c      (redirect_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= REQ;
      pc      <= RESET_PC;
      valid_q <= 1'b0;
      out_q   <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0};
    end else begin
      state   <= state_d;
      pc      <= next_pc_c;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  // A redirect while a request is in flight parks in DRAIN until the stale word returns.
  always_comb begin
    state_d = state;
    valid_d = valid_q;
    out_d   = out_q;
    case (state)
      REQ: begin
        state_d = redirect_c ? DRAIN : WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (redirect_c) begin
            state_d = REQ;
          end else begin
            state_d        = HOLD;
            valid_d        = 1'b1;
            out_d.instr    = imem.imem_rdata;
            out_d.pc       = pc;
            out_d.pc_plus4 = pc + XLEN'(INSTR_BYTES);
          end
        end else if (redirect_c) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (redirect_c || !stall) begin
          state_d     = REQ;
          valid_d     = 1'b0;
          out_d.instr = NOP_INSTR;
        end
      end
      DRAIN: begin
        if (imem.imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  assign imem.imem_req  = (state == REQ) && !rst;
  assign imem.imem_addr = pc;

  assign if_valid    = valid_q;
  assign if_instr    = out_q.instr;
  assign if_pc       = out_q.pc;
  assign if_pc_plus4 = out_q.pc_plus4;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the CPU. Holds the program counter, issues single-outstanding requests to instruction memory, and presents one fetched instruction at a time to decode under a valid/stall handshake. Redirects come from downstream:
- Branches arrive as PC+4 plus a word offset that decode has already scaled ×4 by its left-shift-by-2 shifter.
- Jumps arrive as an absolute target.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, value driven on if_instr while no instruction is held.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous and active-high.
- imem_req  out  1  one-cycle request strobe to instruction memory.
- imem_addr  out  32  request address, equal to current PC.
- imem_rdata  in  32  returned instruction word.
- imem_rvalid  in  1  response strobe, at least 1 cycle after imem_req.
- stall  in  1  decode cannot accept the offered instruction.
- branch_taken  in  1  branch redirect request.
- branch_pc_plus4  in  32  PC+4 of the branching instruction.
- branch_offset  in  32  sign-extended immediate already shifted left by 2.
- jump_en  in  1  jump redirect request.
- jump_target  in  32  absolute jump address.
- if_valid  out  1  if_instr/if_pc hold a live instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- if_pc_plus4  out  32  if_pc + 4.

## Operation
- Redirect = jump_en | branch_taken.
- Redirect priority: rst > jump_en > branch_taken > sequential.
- Targets:
  - Jump target = jump_target.
  - Branch target = branch_pc_plus4 + branch_offset.
  - All sums are mod 2^32, so 0xFFFF_FFFC + 4 = 0.
  - Target bits [1:0] are forced to 0.
- States:
  - REQ: imem_req=1, imem_addr=pc.
    - Redirect: pc←target, go to DRAIN.
    - Otherwise: go to WAIT.
  - WAIT:
    - rvalid with no redirect: capture if_instr←rdata, if_pc←pc, if_pc_plus4←pc+4, if_valid←1; go to HOLD.
    - rvalid with redirect: discard the word, pc←target, go to REQ.
    - Redirect without rvalid: pc←target, go to DRAIN.
  - HOLD: instruction is offered.
    - Redirect: if_valid←0, if_instr←NOP_INSTR, pc←target, go to REQ. The offered instruction is dropped even if stall=0.
    - stall=0: transfer happens; pc←pc+4, if_valid←0, go to REQ.
    - stall=1: all outputs held, stay in HOLD.
  - DRAIN: waits for the stale response.
    - rvalid: discard the word, go to REQ.
    - Any redirect in DRAIN (with or without rvalid) updates pc; the latest redirect wins.
- Stall is ignored outside HOLD.
- imem_rvalid arriving in REQ or HOLD is a protocol error. The block ignores it.

## Timing
- Reset values:
  - state=REQ, pc=RESET_PC.
  - imem_req=0 while rst=1.
  - imem_addr=RESET_PC.
  - if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=0.
- First request is in the first cycle with rst=0.
- imem_req = (state==REQ) & ~rst; it is never high in two consecutive cycles.
- imem_addr tracks pc combinationally.
- Outputs if_* are registered.
- Latency with 1-cycle memory:
  - req at N, rvalid at N+1, if_valid=1 at N+2.
  - If not stalled, next req at N+3, giving 3 cycles per instruction.
- Reset mid-operation:
  - Returns to REQ at RESET_PC and drops any held instruction.
  - Instruction memory shares rst, so there are no stale responses after reset.

## Structure
- The following belong in the shared CPU header (cpu.svh):
  - fetch_state_t enum {REQ, WAIT, HOLD, DRAIN}.
  - INSTR_BYTES=4.
  - Default NOP encoding.
- One combinational sub-module, next_pc_mux:
  - Inputs: pc, redirect inputs, advance.
  - Outputs: next pc and redirect flag.
  - Applies the priority and [1:0] masking.
- FSM, pc register, and output registers stay in fetch_unit.

## Test plan
- Reset release, 1-cycle memory returning 0x1111_0000+addr, stall=0:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - if_valid pulses every 3rd cycle; if_pc_plus4 = if_pc+4.
- Stall=1 for 5 cycles while in HOLD at pc=0x8:
  - if_valid, if_instr, if_pc stable for all 5 cycles.
  - No imem_req until the cycle after stall drops.
- Branch in HOLD with branch_pc_plus4=0x10, branch_offset=0xFFFF_FFF0 (−4 words ×4):
  - if_valid=0 next cycle; next imem_addr=0x0.
- jump_en and branch_taken in the same cycle, jump_target=0x400:
  - Next imem_addr=0x400.
- Redirect to 0x200 during WAIT, memory latency 3:
  - Stale rvalid data never appears on if_instr.
  - Exactly one request is issued, to 0x200, after the rvalid.
- Wrap-around: jump to 0xFFFF_FFFC, then sequential advance:
  - Next imem_addr=0x0.
- Reset asserted in HOLD:
  - All outputs take their reset values next cycle.
